fuzzy_rule_aggregator: RTL



---
 rtl/fuzzy_rule_aggregator.sv | 130 +++++++++++++
 1 files changed

// File: rtl/fuzzy_rule_aggregator.sv
`default_nettype none
// ============================================================================
// Module      : fuzzy_rule_aggregator
// Description : Max-aggregates RULE_COUNT comparator-tree results per frame and
//               emits the strongest rule and its index on a valid/ready port.
// Revision    : 1.0 - initial release
// ============================================================================
module fuzzy_rule_aggregator #(
    parameter int DATA_WIDTH   = 3,
    parameter int RULE_COUNT   = 4,
    parameter int PIPE_LATENCY = 2,
    localparam int IDX_W       = (RULE_COUNT > 2) ? $clog2(RULE_COUNT) : 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  io_start,
    input  logic                  io_inValid,
    input  logic [DATA_WIDTH-1:0] io_ruleResult,
    output logic                  io_out_valid,
    input  logic                  io_out_ready,
    output logic [DATA_WIDTH-1:0] io_out_bits,
    output logic [IDX_W-1:0]      io_out_ruleIndex,
    output logic                  io_busy,
    output logic                  io_overflow
);

    localparam logic [IDX_W-1:0] c_LAST_IDX = IDX_W'(RULE_COUNT - 1);

    logic [PIPE_LATENCY-1:0] r_tok_q,       w_tok_d;
    logic                    r_start_q,     w_start_d;
    logic [DATA_WIDTH-1:0]   r_acc_q,       w_acc_d;
    logic [IDX_W-1:0]        r_acc_idx_q,   w_acc_idx_d;
    logic [IDX_W-1:0]        r_count_q,     w_count_d;
    logic                    r_out_valid_q, w_out_valid_d;
    logic [DATA_WIDTH-1:0]   r_out_bits_q,  w_out_bits_d;
    logic [IDX_W-1:0]        r_out_idx_q,   w_out_idx_d;
    logic                    r_overflow_q,  w_overflow_d;

    logic                    w_acc_en;
    logic                    w_last;
    logic                    w_load;
    logic [DATA_WIDTH-1:0]   w_max;
    logic [IDX_W-1:0]        w_max_idx;

    // Token pipe moves only when the upstream tree's enable moves its data.
    always_comb begin
        w_tok_d   = r_tok_q;
        w_start_d = io_start;
        if (io_start) begin
            w_tok_d[0] = io_inValid;
            for (int i = 1; i < PIPE_LATENCY; i++) begin
                w_tok_d[i] = r_tok_q[i-1];
            end
        end
    end

    always_comb begin
        w_acc_en = r_start_q & r_tok_q[PIPE_LATENCY-1];
        w_last   = (r_count_q == c_LAST_IDX);

        // First rule of a frame always loads; later rules win only on strict greater.
        if ((r_count_q == '0) || (io_ruleResult > r_acc_q)) begin
            w_max     = io_ruleResult;
            w_max_idx = r_count_q;
        end else begin
            w_max     = r_acc_q;
            w_max_idx = r_acc_idx_q;
        end

        w_load = w_acc_en & w_last & (~r_out_valid_q | io_out_ready);

        w_acc_d       = r_acc_q;
        w_acc_idx_d   = r_acc_idx_q;
        w_count_d     = r_count_q;
        w_out_valid_d = r_out_valid_q;
        w_out_bits_d  = r_out_bits_q;
        w_out_idx_d   = r_out_idx_q;
        w_overflow_d  = r_overflow_q;

        if (w_acc_en) begin
            w_acc_d     = w_max;
            w_acc_idx_d = w_max_idx;
            w_count_d   = w_last ? '0 : r_count_q + IDX_W'(1);
            if (w_last && !w_load) begin
                w_overflow_d = 1'b1;
            end
        end

        if (r_out_valid_q && io_out_ready) begin
            w_out_valid_d = 1'b0;
        end
        if (w_load) begin
            w_out_valid_d = 1'b1;
            w_out_bits_d  = w_max;
            w_out_idx_d   = w_max_idx;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_tok_q       <= '0;
            r_start_q     <= 1'b0;
            r_acc_q       <= '0;
            r_acc_idx_q   <= '0;
            r_count_q     <= '0;
            r_out_valid_q <= 1'b0;
            r_out_bits_q  <= '0;
            r_out_idx_q   <= '0;
            r_overflow_q  <= 1'b0;
        end else begin
            r_tok_q       <= w_tok_d;
            r_start_q     <= w_start_d;
            r_acc_q       <= w_acc_d;
            r_acc_idx_q   <= w_acc_idx_d;
            r_count_q     <= w_count_d;
            r_out_valid_q <= w_out_valid_d;
            r_out_bits_q  <= w_out_bits_d;
            r_out_idx_q   <= w_out_idx_d;
            r_overflow_q  <= w_overflow_d;
        end
    end

    assign io_out_valid     = r_out_valid_q;
    assign io_out_bits      = r_out_bits_q;
    assign io_out_ruleIndex = r_out_idx_q;
    assign io_busy          = (r_count_q != '0);
    assign io_overflow      = r_overflow_q;

endmodule
`default_nettype wire
